// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename stage: register file sizes, tag widths,
// the renamed-lane record and a saturating counter helper.
package rename_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int AW        = $clog2(ARCH_REGS);
    localparam int PW        = $clog2(PHYS_REGS);
    localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;

    typedef logic [AW-1:0] arch_t;
    typedef logic [PW-1:0] phys_t;

    typedef struct packed {
        phys_t       ps1;
        phys_t       ps2;
        phys_t       pd;
        phys_t       old_pd;
        logic [31:0] instr;
    } renamed_lane_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rename_stage_nw_if.sv
// Decode-side, dispatch-side and retire-side signals of the rename stage.
// master = the surrounding pipeline, slave = rename_stage_nw.
interface rename_stage_nw_if
    import rename_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int RET_LANES = 2
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_has_rd;
    logic [LANES*AW-1:0]     in_rs1;
    logic [LANES*AW-1:0]     in_rs2;
    logic [LANES*AW-1:0]     in_rd;
    logic [LANES*32-1:0]     in_instr;
    logic [31:0]             in_pc;

    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*PW-1:0]     out_ps1;
    logic [LANES*PW-1:0]     out_ps2;
    logic [LANES*PW-1:0]     out_pd;
    logic [LANES*PW-1:0]     out_old_pd;
    logic [LANES*32-1:0]     out_instr;
    logic [31:0]             out_pc;

    logic [RET_LANES-1:0]    ret_valid;
    logic [RET_LANES*PW-1:0] ret_tag;
    logic [PW:0]             fl_count;

    modport master (
        output in_valid, in_has_rd, in_rs1, in_rs2, in_rd, in_instr, in_pc,
        output out_ready, ret_valid, ret_tag,
        input  in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
        input  out_instr, out_pc, fl_count
    );

    modport slave (
        input  in_valid, in_has_rd, in_rs1, in_rs2, in_rd, in_instr, in_pc,
        input  out_ready, ret_valid, ret_tag,
        output in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
        output out_instr, out_pc, fl_count
    );

endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical tags: up to LANES pops from head and
// RET_LANES compacted pushes at tail per cycle; pushes are visible next cycle.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int RET_LANES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(LANES+1)-1:0]   pop_cnt,
    output phys_t                        pop_tag [LANES],
    input  logic [RET_LANES-1:0]         push_valid,
    input  phys_t                        push_tag [RET_LANES],
    output logic [PW:0]                  count
);

    localparam int FW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    typedef logic [FW-1:0] ptr_t;

    phys_t       mem_q [FL_DEPTH];
    phys_t       mem_d [FL_DEPTH];
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    logic [PW:0] count_q, count_d;
    int          n_push;
    logic        overflow;

    function automatic ptr_t ptr_add(input ptr_t p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= FL_DEPTH) s = s - FL_DEPTH;
        return ptr_t'(s);
    endfunction

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            pop_tag[k] = mem_q[ptr_add(head_q, k)];
        end
    end

    // Tag 0 is never returned; pushes beyond capacity are dropped and flagged.
    always_comb begin
        mem_d    = mem_q;
        n_push   = 0;
        overflow = 1'b0;
        for (int i = 0; i < RET_LANES; i++) begin
            if (push_valid[i] && push_tag[i] != '0) begin
                if (int'(count_q) + n_push < FL_DEPTH) begin
                    mem_d[ptr_add(tail_q, n_push)] = push_tag[i];
                    n_push = n_push + 1;
                end else begin
                    overflow = 1'b1;
                end
            end
        end
        head_d  = ptr_add(head_q, int'(pop_cnt));
        tail_d  = ptr_add(tail_q, n_push);
        count_d = count_q - (PW+1)'(pop_cnt) + (PW+1)'(n_push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PW'(ARCH_REGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= (PW+1)'(FL_DEPTH);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    assert property (@(posedge clk) disable iff (!rst_n) !overflow)
        else $error("rename_free_list: retire push beyond capacity dropped");

endmodule

// File: rtl/rename_stage_nw.sv
// Registered N-lane rename stage: RAT lookup with intra-group bypass, free-list
// allocation, valid/ready output register. Optional stall counters: RENAME_STALL_CNT_EN.
module rename_stage_nw
    import rename_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int RET_LANES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    rename_stage_nw_if.slave   bus
`ifdef RENAME_STALL_CNT_EN
    ,
    output logic [31:0]        stall_free_cnt,
    output logic [31:0]        stall_bp_cnt
`endif
);

    localparam int CW = $clog2(LANES+1);

    arch_t            rs1 [LANES];
    arch_t            rs2 [LANES];
    arch_t            rd  [LANES];
    logic [LANES-1:0] is_real;

    phys_t            rat_q [ARCH_REGS];
    phys_t            rat_d [ARCH_REGS];
    renamed_lane_t    lane_q [LANES];
    renamed_lane_t    lane_d [LANES];
    logic [31:0]      pc_q, pc_d;
    logic             out_valid_q, out_valid_d;

    phys_t            pop_tag  [LANES];
    phys_t            push_tag [RET_LANES];
    phys_t            pd   [LANES];
    phys_t            ps1  [LANES];
    phys_t            ps2  [LANES];
    phys_t            old  [LANES];
    logic [CW-1:0]    pop_cnt;
    logic [PW:0]      fl_count;
    logic             in_ready;
    logic             accept;

    always_comb begin
        is_real = '0;
        for (int k = 0; k < LANES; k++) begin
            rs1[k]     = bus.in_rs1[k*AW +: AW];
            rs2[k]     = bus.in_rs2[k*AW +: AW];
            rd[k]      = bus.in_rd[k*AW +: AW];
            is_real[k] = bus.in_has_rd[k] && (bus.in_rd[k*AW +: AW] != '0);
        end
        for (int r = 0; r < RET_LANES; r++) begin
            push_tag[r] = bus.ret_tag[r*PW +: PW];
        end
    end

    // Readiness ignores has_rd so it never depends on the group being offered.
    assign in_ready = (!out_valid_q || bus.out_ready) && (fl_count >= (PW+1)'(LANES));
    assign accept   = bus.in_valid && in_ready;
    assign pop_cnt  = accept ? CW'($countones(is_real)) : '0;

    always_comb begin
        int n_alloc;
        n_alloc = 0;
        for (int k = 0; k < LANES; k++) begin
            pd[k] = '0;
            if (is_real[k]) begin
                pd[k]   = pop_tag[n_alloc];
                n_alloc = n_alloc + 1;
            end
        end
    end

    // Later lanes see the newest in-group producer; ascending j lets the highest win.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            ps1[k] = (rs1[k] == '0) ? '0 : rat_q[rs1[k]];
            ps2[k] = (rs2[k] == '0) ? '0 : rat_q[rs2[k]];
            old[k] = rat_q[rd[k]];
            for (int j = 0; j < k; j++) begin
                if (is_real[j]) begin
                    if (rd[j] == rs1[k]) ps1[k] = pd[j];
                    if (rd[j] == rs2[k]) ps2[k] = pd[j];
                    if (rd[j] == rd[k])  old[k] = pd[j];
                end
            end
            if (!is_real[k]) old[k] = '0;
        end
    end

    always_comb begin
        rat_d       = rat_q;
        lane_d      = lane_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            pc_d        = bus.in_pc;
            for (int k = 0; k < LANES; k++) begin
                lane_d[k].ps1    = ps1[k];
                lane_d[k].ps2    = ps2[k];
                lane_d[k].pd     = pd[k];
                lane_d[k].old_pd = old[k];
                lane_d[k].instr  = bus.in_instr[k*32 +: 32];
                if (is_real[k]) rat_d[rd[k]] = pd[k];
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= PW'(i);
            end
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
            pc_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rat_q       <= rat_d;
            lane_q      <= lane_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
        end
    end

    rename_free_list #(
        .LANES     (LANES),
        .RET_LANES (RET_LANES)
    ) u_free_list (
        .clk        (clk),
        .rst_n      (rst_n),
        .pop_cnt    (pop_cnt),
        .pop_tag    (pop_tag),
        .push_valid (bus.ret_valid),
        .push_tag   (push_tag),
        .count      (fl_count)
    );

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            bus.out_ps1[k*PW +: PW]    = lane_q[k].ps1;
            bus.out_ps2[k*PW +: PW]    = lane_q[k].ps2;
            bus.out_pd[k*PW +: PW]     = lane_q[k].pd;
            bus.out_old_pd[k*PW +: PW] = lane_q[k].old_pd;
            bus.out_instr[k*32 +: 32]  = lane_q[k].instr;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = pc_q;
    assign bus.in_ready  = in_ready;
    assign bus.fl_count  = fl_count;

`ifdef RENAME_STALL_CNT_EN
    logic [31:0] stall_free_cnt_q, stall_free_cnt_d;
    logic [31:0] stall_bp_cnt_q, stall_bp_cnt_d;

    always_comb begin
        stall_free_cnt_d = stall_free_cnt_q;
        stall_bp_cnt_d   = stall_bp_cnt_q;
        if (bus.in_valid && fl_count < (PW+1)'(LANES)) stall_free_cnt_d = sat_inc32(stall_free_cnt_q);
        if (bus.in_valid && out_valid_q && !bus.out_ready) stall_bp_cnt_d = sat_inc32(stall_bp_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_free_cnt_q <= '0;
            stall_bp_cnt_q   <= '0;
        end else begin
            stall_free_cnt_q <= stall_free_cnt_d;
            stall_bp_cnt_q   <= stall_bp_cnt_d;
        end
    end

    assign stall_free_cnt = stall_free_cnt_q;
    assign stall_bp_cnt   = stall_bp_cnt_q;
`endif

endmodule
